key_note_select: RTL

Upstream stage of the piano tone path. Synchronizes and debounces eight raw key inputs (one octave, C4..C5) and selects the lowest pressed key. It outputs the matching half-period terminal count for the square-wave tone generator, which toggles the speaker each time its counter reaches that value. A one-cycle load strobe tells the tone generator when the note changes, so it can restart its counter cleanly.

---
 rtl/key_note_select.sv | 125 ++++++++++++
 1 files changed

// File: rtl/key_note_select.sv
// Key synchronizer, per-key debouncer and lowest-key note selector for the piano tone path.
// Optional feature: define OCTAVE_UP_EN to add the octave_up input, which halves the tone period.
module key_note_select #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  keys,
`ifdef OCTAVE_UP_EN
    input  logic        octave_up,
`endif
    output logic        note_valid,
    output logic [2:0]  note_idx,
    output logic [16:0] half_period,
    output logic        note_load,
    output logic [7:0]  keys_db
);

    localparam logic [19:0] DB_LIMIT = 20'(DEBOUNCE_CYCLES);

    logic [7:0]  keysSync1;
    logic [7:0]  keysSync2;
    logic [7:0]  stable;
    logic [19:0] dbCount [8];

    logic        selValid;
    logic [2:0]  selIdx;
    logic [16:0] selHalf;
    logic        octaveSync;

    // A key flips only after DB_LIMIT consecutive mismatching cycles; any match restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keysSync1 <= '0;
            keysSync2 <= '0;
            stable    <= '0;
            for (int i = 0; i < 8; i++) begin
                dbCount[i] <= '0;
            end
        end else begin
            keysSync1 <= keys;
            keysSync2 <= keysSync1;
            for (int i = 0; i < 8; i++) begin
                if (keysSync2[i] == stable[i]) begin
                    dbCount[i] <= '0;
                end else if (dbCount[i] == DB_LIMIT) begin
                    stable[i]  <= keysSync2[i];
                    dbCount[i] <= '0;
                end else begin
                    dbCount[i] <= dbCount[i] + 20'd1;
                end
            end
        end
    end

    assign keys_db = stable;

`ifdef OCTAVE_UP_EN
    logic octaveSync1;
    logic octaveSync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            octaveSync1 <= 1'b0;
            octaveSync2 <= 1'b0;
        end else begin
            octaveSync1 <= octave_up;
            octaveSync2 <= octaveSync1;
        end
    end

    assign octaveSync = octaveSync2;
`else
    assign octaveSync = 1'b0;
`endif

    // Half-period counts N at 50 MHz, C4 up to C5.
    function automatic logic [16:0] baseCount(input logic [2:0] idx);
        case (idx)
            3'd0:    baseCount = 17'd95556;
            3'd1:    baseCount = 17'd85131;
            3'd2:    baseCount = 17'd75843;
            3'd3:    baseCount = 17'd71586;
            3'd4:    baseCount = 17'd63776;
            3'd5:    baseCount = 17'd56818;
            3'd6:    baseCount = 17'd50619;
            default: baseCount = 17'd47778;
        endcase
    endfunction

    // Lowest pressed key wins; iterating downward lets the lowest index overwrite.
    always_comb begin
        selValid = 1'b0;
        selIdx   = 3'd0;
        selHalf  = 17'd0;
        for (int i = 7; i >= 0; i--) begin
            if (stable[i]) begin
                selValid = 1'b1;
                selIdx   = 3'(i);
            end
        end
        if (selValid) begin
            if (octaveSync) begin
                selHalf = (baseCount(selIdx) >> 1) - 17'd1;
            end else begin
                selHalf = baseCount(selIdx) - 17'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_valid  <= 1'b0;
            note_idx    <= 3'd0;
            half_period <= 17'd0;
            note_load   <= 1'b0;
        end else begin
            note_valid  <= selValid;
            note_idx    <= selIdx;
            half_period <= selHalf;
            note_load   <= {selValid, selIdx, selHalf} != {note_valid, note_idx, half_period};
        end
    end

endmodule
